// File: rtl/ctrl_serial2d_if.sv
// Operand handshake and datapath control bundle between a producer and ctrl_serial2d.
// master = producer side (drives operands, observes controls); slave = the sequencer.
interface ctrl_serial2d_if;
   logic [3:0] mode;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] w_in;
   logic [7:0] a_in;
   logic       acc_clr;
   logic [7:0] w;
   logic [7:0] a;
   logic [2:0] w_sel;
   logic [2:0] a_sel;
   logic       sign_ctr;
   logic       shift_ctr;
   logic       rst_mult;
   logic       rst_acc;
   logic       acc_en;
   logic       busy;
   logic       mode_err;

   modport master (
      output mode, in_valid, w_in, a_in, acc_clr,
      input  in_ready, w, a, w_sel, a_sel, sign_ctr, shift_ctr,
             rst_mult, rst_acc, acc_en, busy, mode_err
   );

   modport slave (
      input  mode, in_valid, w_in, a_in, acc_clr,
      output in_ready, w, a, w_sel, a_sel, sign_ctr, shift_ctr,
             rst_mult, rst_acc, acc_en, busy, mode_err
   );
endinterface

// File: rtl/ctrl_serial2d.sv
// Bit-pair sequencer for the 2D bit-serial MAC: walks the anti-diagonal schedule, acc_en m*n+2 cycles after accept.
// Accepts a new pair only in IDLE or ACC with a legal mode; in_ready is low through LOAD and RUN.
module ctrl_serial2d #(
   parameter int HEADROOM = 4
) (
   input  logic            clk_fast,
   input  logic            rst,
   ctrl_serial2d_if.slave  bus
);

   // HEADROOM only sizes the datapath accumulator; nothing here depends on it.
   if (HEADROOM < 0) begin : g_headroom_negative
   end

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ACC} state_t;

   state_t     r_state;
   logic [3:0] r_m, r_n;
   logic [3:0] r_i;
   logic [2:0] r_j;
   logic [7:0] r_w, r_a;
   logic [2:0] r_w_sel, r_a_sel;
   logic       r_sign_ctr, r_shift_ctr, r_rst_mult, r_rst_acc, r_acc_en;

   logic [3:0] w_m, w_n;
   logic       w_mode_err, w_in_ready, w_accept;
   logic [3:0] w_j4, w_jhi, w_nxt_i, w_nxt_jlo, w_nxt_j;
   logic [2:0] w_nxt_asel;
   logic       w_last, w_new_diag, w_nxt_sign;

   always_comb begin
      w_m        = 4'd8;
      w_n        = 4'd8;
      w_mode_err = 1'b0;
      case (bus.mode)
         4'b0000: begin w_m = 4'd8; w_n = 4'd8; end
         4'b0111: begin w_m = 4'd4; w_n = 4'd4; end
         4'b1111: begin w_m = 4'd2; w_n = 4'd2; end
         4'b0001: begin w_m = 4'd8; w_n = 4'd4; end
         4'b0011: begin w_m = 4'd8; w_n = 4'd2; end
         default: w_mode_err = 1'b1;
      endcase
   end

   assign w_in_ready = ((r_state == S_IDLE) || (r_state == S_ACC)) && !w_mode_err;
   assign w_accept   = bus.in_valid && w_in_ready;

   // Next step on the anti-diagonal: advance j until min(i, n-1), then start diagonal i+1 at max(0, i+1-m+1).
   always_comb begin
      w_j4       = {1'b0, r_j};
      w_jhi      = (r_i < (r_n - 4'd1)) ? r_i : (r_n - 4'd1);
      w_last     = (r_i == (r_m + r_n - 4'd2)) && (w_j4 == (r_n - 4'd1));
      w_new_diag = (w_j4 == w_jhi);
      w_nxt_i    = w_new_diag ? (r_i + 4'd1) : r_i;
      w_nxt_jlo  = (w_nxt_i >= r_m) ? (w_nxt_i - r_m + 4'd1) : 4'd0;
      w_nxt_j    = w_new_diag ? w_nxt_jlo : (w_j4 + 4'd1);
      w_nxt_asel = w_nxt_i[2:0] - w_nxt_j[2:0];
      w_nxt_sign = (w_nxt_j == (r_n - 4'd1));
   end

   always_ff @(posedge clk_fast) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_m         <= 4'd0;
         r_n         <= 4'd0;
         r_i         <= 4'd0;
         r_j         <= 3'd0;
         r_w         <= 8'd0;
         r_a         <= 8'd0;
         r_w_sel     <= 3'd0;
         r_a_sel     <= 3'd0;
         r_sign_ctr  <= 1'b0;
         r_shift_ctr <= 1'b0;
         r_rst_mult  <= 1'b0;
         r_rst_acc   <= 1'b0;
         r_acc_en    <= 1'b0;
      end else begin
         r_rst_acc   <= w_in_ready && bus.acc_clr;
         r_rst_mult  <= 1'b0;
         r_acc_en    <= 1'b0;
         r_w_sel     <= 3'd0;
         r_a_sel     <= 3'd0;
         r_sign_ctr  <= 1'b0;
         r_shift_ctr <= 1'b0;
         case (r_state)
            S_IDLE, S_ACC: begin
               if (w_accept) begin
                  r_state    <= S_LOAD;
                  r_m        <= w_m;
                  r_n        <= w_n;
                  r_w        <= bus.w_in;
                  r_a        <= bus.a_in;
                  r_rst_mult <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_LOAD: begin
               r_state <= S_RUN;
               r_i     <= 4'd0;
               r_j     <= 3'd0;
            end
            S_RUN: begin
               if (w_last) begin
                  r_state  <= S_ACC;
                  r_acc_en <= 1'b1;
               end else begin
                  r_i         <= w_nxt_i;
                  r_j         <= w_nxt_j[2:0];
                  r_w_sel     <= w_nxt_j[2:0];
                  r_a_sel     <= w_nxt_asel;
                  r_sign_ctr  <= w_nxt_sign;
                  r_shift_ctr <= w_new_diag;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.mode_err  = w_mode_err;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.w         = r_w;
   assign bus.a         = r_a;
   assign bus.w_sel     = r_w_sel;
   assign bus.a_sel     = r_a_sel;
   assign bus.sign_ctr  = r_sign_ctr;
   assign bus.shift_ctr = r_shift_ctr;
   assign bus.rst_mult  = r_rst_mult;
   assign bus.rst_acc   = r_rst_acc;
   assign bus.acc_en    = r_acc_en;

endmodule

// File: tb/tb_ctrl_serial2d.sv
// Directed + randomized bench for ctrl_serial2d; expected schedule built from (i,j) loops over the bit-pair grid.
module tb_ctrl_serial2d;

   logic clk = 1'b0;
   logic rst;
   ctrl_serial2d_if bus ();

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_err  = 0;
   int cyc    = 0;
   int t_pres = 0;

   always @(posedge clk) cyc++;

   ctrl_serial2d #(.HEADROOM(4)) dut (
      .clk_fast (clk),
      .rst      (rst),
      .bus      (bus)
   );

   logic [3:0] legal_modes [5] = '{4'b0000, 4'b0111, 4'b1111, 4'b0001, 4'b0011};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit decode(input logic [3:0] md, output int m, output int n);
      case (md)
         4'b0000: begin m = 8; n = 8; return 1'b1; end
         4'b0111: begin m = 4; n = 4; return 1'b1; end
         4'b1111: begin m = 2; n = 2; return 1'b1; end
         4'b0001: begin m = 8; n = 4; return 1'b1; end
         4'b0011: begin m = 8; n = 2; return 1'b1; end
         default: begin m = 0; n = 0; return 1'b0; end
      endcase
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_w"},         bus.w, 0);
      chk({tag, "_a"},         bus.a, 0);
      chk({tag, "_w_sel"},     bus.w_sel, 0);
      chk({tag, "_a_sel"},     bus.a_sel, 0);
      chk({tag, "_sign_ctr"},  bus.sign_ctr, 0);
      chk({tag, "_shift_ctr"}, bus.shift_ctr, 0);
      chk({tag, "_rst_mult"},  bus.rst_mult, 0);
      chk({tag, "_rst_acc"},   bus.rst_acc, 0);
      chk({tag, "_acc_en"},    bus.acc_en, 0);
      chk({tag, "_busy"},      bus.busy, 0);
   endtask

   // Called at a negedge where the DUT is in IDLE or ACC: offers a pair for the next edge.
   task automatic present(input logic [3:0] md, input logic [7:0] wv, input logic [7:0] av, input logic clr);
      bus.mode     = md;
      bus.w_in     = wv;
      bus.a_in     = av;
      bus.acc_clr  = clr;
      bus.in_valid = 1'b1;
      #1;
      chk("accept_in_ready", bus.in_ready, 1);
      chk("accept_mode_err", bus.mode_err, 0);
      t_pres = cyc;
   endtask

   // Follows one accepted pair through LOAD, RUN and ACC; returns at the ACC negedge.
   task automatic follow(input logic [3:0] md, input logic [7:0] wv, input logic [7:0] av,
                         input logic clr, input bit hold);
      int m, n, jlo, jhi;
      void'(decode(md, m, n));
      @(negedge clk);
      bus.acc_clr = 1'b0;
      if (!hold) bus.in_valid = 1'b0;
      chk("load_busy",     bus.busy, 1);
      chk("load_rst_mult", bus.rst_mult, 1);
      chk("load_rst_acc",  bus.rst_acc, clr);
      chk("load_acc_en",   bus.acc_en, 0);
      chk("load_w",        bus.w, wv);
      chk("load_a",        bus.a, av);
      chk("load_in_ready", bus.in_ready, 0);
      for (int i = 0; i <= m + n - 2; i++) begin
         jlo = (i - m + 1 > 0) ? i - m + 1 : 0;
         jhi = (i < n - 1) ? i : n - 1;
         for (int j = jlo; j <= jhi; j++) begin
            if (!hold) begin
               bus.mode    = legal_modes[$urandom_range(0, 4)];
               bus.w_in    = 8'($urandom);
               bus.a_in    = 8'($urandom);
               bus.acc_clr = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("run_a_sel",     bus.a_sel, i - j);
            chk("run_w_sel",     bus.w_sel, j);
            chk("run_sign_ctr",  bus.sign_ctr, (j == n - 1) ? 1 : 0);
            chk("run_shift_ctr", bus.shift_ctr, (i > 0 && j == jlo) ? 1 : 0);
            chk("run_rst_mult",  bus.rst_mult, 0);
            chk("run_rst_acc",   bus.rst_acc, 0);
            chk("run_acc_en",    bus.acc_en, 0);
            chk("run_busy",      bus.busy, 1);
            chk("run_in_ready",  bus.in_ready, 0);
            chk("run_w",         bus.w, wv);
            chk("run_a",         bus.a, av);
         end
      end
      @(negedge clk);
      chk("acc_acc_en",   bus.acc_en, 1);
      chk("acc_busy",     bus.busy, 1);
      chk("acc_rst_mult", bus.rst_mult, 0);
      chk("acc_rst_acc",  bus.rst_acc, 0);
      chk("acc_w",        bus.w, wv);
      chk("acc_a",        bus.a, av);
      chk("acc_latency",  cyc - t_pres, m * n + 2);
      bus.acc_clr = 1'b0;
      #1;
      chk("acc_in_ready", bus.in_ready, 1);
      t_pres = cyc;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      chk({tag, "_busy"},     bus.busy, 0);
      chk({tag, "_acc_en"},   bus.acc_en, 0);
      chk({tag, "_rst_mult"}, bus.rst_mult, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] md;
      logic [7:0] wv, av;
      logic       clr;
      bit         saw_acc;

      rst          = 1'b1;
      bus.mode     = 4'b0000;
      bus.in_valid = 1'b0;
      bus.w_in     = 8'd0;
      bus.a_in     = 8'd0;
      bus.acc_clr  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      chk("reset_in_ready", bus.in_ready, 1);
      chk("reset_mode_err", bus.mode_err, 0);
      rst = 1'b0;

      // 2x2 schedule
      @(negedge clk);
      present(4'b1111, 8'h02, 8'h03, 1'b0);
      follow(4'b1111, 8'h02, 8'h03, 1'b0, 1'b0);
      check_idle("idle_after_2x2");

      // 8x8 with clear on accept
      present(4'b0000, 8'h81, 8'hFF, 1'b1);
      follow(4'b0000, 8'h81, 8'hFF, 1'b1, 1'b0);
      check_idle("idle_after_8x8");

      // 8Ax2W, in_valid held across three pairs
      present(4'b0011, 8'h5A, 8'hC3, 1'b0);
      follow(4'b0011, 8'h5A, 8'hC3, 1'b0, 1'b1);
      follow(4'b0011, 8'h5A, 8'hC3, 1'b0, 1'b1);
      follow(4'b0011, 8'h5A, 8'hC3, 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      check_idle("idle_after_b2b");

      // clear request in IDLE without an accept
      bus.acc_clr = 1'b1;
      @(negedge clk);
      chk("idle_clr_rst_acc", bus.rst_acc, 1);
      chk("idle_clr_busy",    bus.busy, 0);
      bus.acc_clr = 1'b0;
      @(negedge clk);
      chk("idle_clr_pulse_end", bus.rst_acc, 0);

      // illegal mode blocks acceptance, then a legal mode is taken
      bus.mode     = 4'b0101;
      bus.in_valid = 1'b1;
      #1;
      chk("illegal_mode_err", bus.mode_err, 1);
      chk("illegal_in_ready", bus.in_ready, 0);
      repeat (2) begin
         @(negedge clk);
         chk("illegal_busy",     bus.busy, 0);
         chk("illegal_rst_mult", bus.rst_mult, 0);
      end
      wv = 8'($urandom);
      av = 8'($urandom);
      present(4'b0111, wv, av, 1'b0);
      follow(4'b0111, wv, av, 1'b0, 1'b0);
      check_idle("idle_after_4x4");

      // reset during RUN step 10 of 8x8
      present(4'b0000, 8'h3C, 8'hA5, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrun_reset");
      chk("midrun_reset_in_ready", bus.in_ready, 1);
      rst = 1'b0;
      saw_acc = 1'b0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk);
         if (bus.acc_en === 1'b1 || bus.busy === 1'b1) saw_acc = 1'b1;
      end
      chk("midrun_no_acc_en", saw_acc, 0);

      // randomized pairs with random gaps and back-to-back accepts
      for (int p = 0; p < 10; p++) begin
         md  = legal_modes[$urandom_range(0, 4)];
         wv  = 8'($urandom);
         av  = 8'($urandom);
         clr = 1'($urandom_range(0, 1));
         present(md, wv, av, clr);
         follow(md, wv, av, clr, 1'b0);
         if ($urandom_range(0, 1) == 1) check_idle("rand_gap");
      end
      check_idle("final_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ctrl_serial2d.md
# ctrl_serial2d

Hardware sequencer for the 2D bit-serial MAC datapath (`top_mac_serial2d`). It accepts one (weight, activation) operand pair per valid/ready handshake and walks the anti-diagonal bit-pair schedule for the configured precision mode. For each pair it drives the datapath control lines `w_sel`, `a_sel`, `sign_ctr`, `shift_ctr` and `rst_mult`, plus one accumulate-enable pulse per product. This replaces the gated slow clock with an enable, and removes all per-bit sequencing from software and benches.

## Interface
Parameters
- `HEADROOM`, default 4: accumulator headroom bits; passed through for datapath consistency and not used internally.

Ports
- `clk_fast` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mode` in 4: precision mode. Legal values are 0000 (8Ax8W), 0111 (4x4), 1111 (2x2), 0001 (8Ax4W) and 0011 (8Ax2W).
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `w_in` in 8: signed weight.
- `a_in` in 8: unsigned activation.
- `acc_clr` in 1: clear-accumulator request; honoured only when `in_ready`=1.
- `w` out 8: registered weight to the datapath.
- `a` out 8: registered activation to the datapath.
- `w_sel` out 3: weight bit index j.
- `a_sel` out 3: activation bit index i−j.
- `sign_ctr` out 1: current weight bit is the MSB (j==n−1).
- `shift_ctr` out 1: first step of a new diagonal with i>0.
- `rst_mult` out 1: clear the partial-product register.
- `rst_acc` out 1: clear the accumulator.
- `acc_en` out 1: add the finished product into the accumulator.
- `busy` out 1: state is not IDLE.
- `mode_err` out 1: `mode` is illegal (combinational).

## Operation
- Mode decode gives activation width m and weight width n:
  - 0000 → m=8, n=8
  - 0111 → m=4, n=4
  - 1111 → m=2, n=2
  - 0001 → m=8, n=4
  - 0011 → m=8, n=2
- `mode`, `w_in` and `a_in` are latched on acceptance. `mode` changes at any other time are ignored until the next accept.
- FSM states are IDLE, LOAD, RUN and ACC.
  - IDLE: `in_ready` = !`mode_err`. On `in_valid`&&`in_ready`, latch operands and go to LOAD.
  - LOAD (1 cycle): `rst_mult`=1. Initialise i=0, j=0. Go to RUN.
  - RUN (m·n cycles): each cycle drives `a_sel`=i−j, `w_sel`=j, `sign_ctr`=(j==n−1), and `shift_ctr`=(i>0 && j==max(0,i−m+1)).
    - Step order: i=0..m+n−2; for each i, j=max(0,i−m+1)..min(i,n−1).
    - After the last step (i=m+n−2, j=n−1), go to ACC.
  - ACC (1 cycle): `acc_en`=1. `in_ready` = !`mode_err`. On accept go to LOAD (back-to-back); otherwise go to IDLE.
- `acc_clr`:
  - Sampled only in cycles where `in_ready`=1. `rst_acc` pulses for exactly the next cycle.
  - If `acc_clr` coincides with an accept, the clear lands in LOAD, so the following product accumulates onto zero.
  - `acc_clr` while `in_ready`=0 is dropped.
- Operand widths:
  - `w`/`a` are held unchanged from LOAD through ACC.
  - In reduced-precision modes only the LSB n/m bits are indexed; upper bits pass through unchanged.
  - Sub-width padding is the producer's responsibility.
- `mode_err`: an illegal mode blocks acceptance. It does not abort an operation already in flight, which uses its latched mode.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready`=1 (if mode is legal).
  - `w`, `a`, `w_sel`, `a_sel` = 0.
  - `sign_ctr`, `shift_ctr`, `rst_mult`, `rst_acc`, `acc_en`, `busy` = 0.
- Reset asserted mid-RUN/ACC:
  - Returns to IDLE on the next edge.
  - No `acc_en` is issued for the aborted pair.
  - The accumulator is not cleared by this block.
- All datapath controls are registered (Moore outputs); there is no combinational path from `in_valid` to them. `in_ready` and `mode_err` are combinational from state and `mode`.
- Latency and throughput:
  - Accept at edge t → LOAD in cycle t+1 → RUN in cycles t+2..t+1+m·n → `acc_en` in cycle t+2+m·n.
  - Throughput is one pair per m·n+2 cycles with continuous `in_valid`: 66, 18, 6, 34 and 18 cycles for the five modes.
- `busy`=1 in LOAD, RUN and ACC.

## Test plan
- **Mode 1111, `w_in`=8'h02 (−2 in 2b), `a_in`=8'h03:**
  - RUN is 4 cycles with (a_sel,w_sel) = (0,0),(1,0),(0,1),(1,1).
  - `sign_ctr` = 0,0,1,1.
  - `shift_ctr` = 0,1,0,1.
  - `acc_en` fires 6 cycles after accept.
- **Mode 0000, `w_in`=8'h81, `a_in`=8'hFF:**
  - RUN is exactly 64 cycles; the final step is a_sel=7, w_sel=7, sign_ctr=1.
  - `acc_en` fires at t+66.
  - Datapath z = −32385.
- **Mode 0011, `in_valid` held for 3 pairs:**
  - 16-step RUNs; `acc_en` at t+18, t+36 and t+54.
  - `in_ready` high only in ACC between pairs.
- **`acc_clr` with accept in IDLE:**
  - `rst_acc`=1 coincides with `rst_mult`=1 in LOAD.
- **`acc_clr` asserted during RUN:**
  - No `rst_acc` pulse.
- **Illegal mode 0101 with `in_valid`=1:**
  - `mode_err`=1, `in_ready`=0, and the state stays IDLE.
  - Switching to 0111 while `in_valid` is held gives an accept the next cycle and a 16-step RUN.
- **`rst` asserted at RUN step 10 of mode 0000:**
  - IDLE on the next cycle, all outputs at reset values, and no `acc_en`.
